// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a single-ported data memory.
// Each transaction runs IDLE -> ACCESS -> RESP; all port and memory-side outputs are registered.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic        a_bh,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  output logic        a_err,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic        b_bh,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic        b_err,
  output logic [15:0] b_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_bh,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [16:0] MemBytes = 17'(MEM_BYTES);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;  // 0: A owns priority, 1: B owns priority
  logic        err_q, err_d;
  logic        a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic        a_done_q, a_done_d, b_done_q, b_done_d;
  logic        a_err_q, a_err_d, b_err_q, b_err_d;
  logic [15:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d, mem_bh_q, mem_bh_d;

  logic        pick_b;
  logic        sel_we, sel_bh, sel_err;
  logic [15:0] sel_addr, sel_wdata;
  logic [15:0] cap_rdata;

  assign pick_b    = b_req & (~a_req | prio_q);
  assign sel_we    = pick_b ? b_we    : a_we;
  assign sel_bh    = pick_b ? b_bh    : a_bh;
  assign sel_addr  = pick_b ? b_addr  : a_addr;
  assign sel_wdata = pick_b ? b_wdata : a_wdata;

  // Last byte touched must lie inside the memory; odd halfword alignment is fine.
  assign sel_err = sel_bh ? (({1'b0, sel_addr} + 17'd2) > MemBytes)
                          : (({1'b0, sel_addr} + 17'd1) > MemBytes);

  // mem_read_q is already low for writes and errored accesses.
  assign cap_rdata = !mem_read_q ? 16'h0000 :
                     mem_bh_q    ? mem_rdata : {8'h00, mem_rdata[7:0]};

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    err_d       = err_q;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    a_err_d     = 1'b0;
    b_err_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    mem_addr_d  = 16'h0000;
    mem_wdata_d = 16'h0000;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_bh_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          state_d     = StAccess;
          prio_d      = ~pick_b;
          err_d       = sel_err;
          a_gnt_d     = ~pick_b;
          b_gnt_d     = pick_b;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_bh_d    = sel_bh;
          mem_write_d = sel_we & ~sel_err;
          mem_read_d  = ~sel_we & ~sel_err;
        end
      end
      StAccess: begin
        state_d = StResp;
        if (a_gnt_q) begin
          a_done_d  = 1'b1;
          a_err_d   = err_q;
          a_rdata_d = cap_rdata;
        end
        if (b_gnt_q) begin
          b_done_d  = 1'b1;
          b_err_d   = err_q;
          b_rdata_d = cap_rdata;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Asynchronous reset also kills mem_write before the memory's falling-edge write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      err_q       <= 1'b0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= 16'h0000;
      b_rdata_q   <= 16'h0000;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_bh_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      err_q       <= err_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_bh_q    <= mem_bh_d;
    end
  end

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_done    = a_done_q;
  assign b_done    = b_done_q;
  assign a_err     = a_err_q;
  assign b_err     = b_err_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_bh    = mem_bh_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a little-endian 64-byte memory model plus per-port
// scoreboards of expected read data / error flags popped on each done pulse.
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        a_req, a_we, a_bh, b_req, b_we, b_bh;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_bh, busy;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [0:63];
  bit         mem_init_done = 1'b0;

  dmem_arbiter #(.MEM_BYTES(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_bh     (a_bh),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_done   (a_done),
    .a_err    (a_err),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_bh     (b_bh),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_done   (b_done),
    .b_err    (b_err),
    .b_rdata  (b_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_bh   (mem_bh),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: initial pattern i ^ 0x5A, writes land on the falling edge.
  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem_init_done <= 1'b1;
    end else if (mem_write) begin
      if ({1'b0, mem_addr} < 17'd64) mem[mem_addr[5:0]] <= mem_wdata[7:0];
      if (mem_bh && ({1'b0, mem_addr} + 17'd1 < 17'd64))
        mem[6'(mem_addr[5:0] + 6'd1)] <= mem_wdata[15:8];
    end
  end

  always_comb begin
    mem_rdata = 16'h0000;
    if ({1'b0, mem_addr} < 17'd64) mem_rdata[7:0] = mem[mem_addr[5:0]];
    if ({1'b0, mem_addr} + 17'd1 < 17'd64) mem_rdata[15:8] = mem[6'(mem_addr[5:0] + 6'd1)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [15:0] addr, input bit bh);
    logic [7:0] lo, hi;
    lo = mem[addr[5:0]];
    hi = mem[6'(addr[5:0] + 6'd1)];
    return bh ? {hi, lo} : {8'h00, lo};
  endfunction

  task automatic drive(input bit port, input bit req, input bit we, input bit bh,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (port) begin
      b_req = req; b_we = we; b_bh = bh; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_bh = bh; a_addr = addr; a_wdata = wdata;
    end
  endtask

  task automatic push_exp(input bit port, input bit we, input bit bh, input logic [15:0] addr);
    exp_t e;
    e.err   = bh ? (addr > 16'd62) : (addr > 16'd63);
    e.rdata = (we || e.err) ? 16'h0000 : model_rd(addr, bh);
    if (port) exp_b.push_back(e);
    else      exp_a.push_back(e);
  endtask

  // One transaction from an idle arbiter; called just after a rising edge.
  task automatic single(input bit port, input bit we, input bit bh,
                        input logic [15:0] addr, input logic [15:0] wdata);
    bit err_e;
    err_e = bh ? (addr > 16'd62) : (addr > 16'd63);
    push_exp(port, we, bh, addr);
    drive(port, 1'b1, we, bh, addr, wdata);
    @(posedge clk); #1;
    chk("gnt", {a_gnt, b_gnt, busy}, port ? 3'b011 : 3'b101);
    chk("mem_ctl", {mem_read, mem_write, mem_bh, mem_addr}, {~we & ~err_e, we & ~err_e, bh, addr});
    if (we) chk("mem_wdata", mem_wdata, wdata);
    drive(port, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    chk("done", {a_done, b_done, a_gnt, b_gnt, mem_read, mem_write, busy},
        port ? 7'b0100001 : 7'b1000001);
    @(posedge clk); #1;
    chk("idle", {busy, a_done, b_done}, 3'b000);
  endtask

  // Scoreboard: every done pulse must match the oldest expectation for that port.
  always @(negedge clk) begin : sb
    exp_t e;
    if (a_done) begin
      chk("a_done_expected", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) begin
        e = exp_a.pop_front();
        chk("a_rdata", a_rdata, e.rdata);
        chk("a_err", a_err, e.err);
      end
    end
    if (b_done) begin
      chk("b_done_expected", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) begin
        e = exp_b.pop_front();
        chk("b_rdata", b_rdata, e.rdata);
        chk("b_err", b_err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {a_gnt, b_gnt, a_done, b_done, a_err, b_err, busy,
                      mem_read, mem_write, mem_bh}, 10'h000);
    chk("reset_rdata", {a_rdata, b_rdata}, 32'h0);
    chk("reset_mem_bus", {mem_addr, mem_wdata}, 32'h0);
    reset = 1'b0;

    // Halfword write then read-back, byte read of the upper half.
    single(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    chk("mem_10_11", {mem[17], mem[16]}, 16'hBEEF);
    single(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000);
    chk("a_rdata_beef", a_rdata, 16'hBEEF);
    single(1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000);
    chk("b_rdata_00be", b_rdata, 16'h00BE);

    // Byte write only touches one byte; odd-aligned halfword read.
    single(1'b1, 1'b1, 1'b0, 16'h0005, 16'h1234);
    chk("mem_5_6", {mem[6], mem[5]}, 16'h5C34);
    single(1'b0, 1'b0, 1'b1, 16'h000F, 16'h0000);
    chk("a_rdata_odd_hw", a_rdata, 16'hEF55);

    // Address-error boundaries.
    single(1'b0, 1'b0, 1'b1, 16'd63, 16'h0000);
    single(1'b0, 1'b0, 1'b0, 16'd64, 16'h0000);
    single(1'b0, 1'b0, 1'b0, 16'd63, 16'h0000);
    chk("a_rdata_byte63", a_rdata, 16'h0065);
    single(1'b1, 1'b0, 1'b1, 16'd62, 16'h0000);
    chk("b_rdata_hw62", b_rdata, 16'h6564);
    single(1'b1, 1'b1, 1'b1, 16'd63, 16'hAAAA);
    chk("mem_63_kept", mem[63], 8'h65);
    chk("a_rdata_held", a_rdata, 16'h0065);

    // Both ports requesting continuously straight after reset: A, B, A, B.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      push_exp(1'b0, 1'b0, 1'b1, 16'h0010);
      push_exp(1'b1, 1'b0, 1'b0, 16'h0011);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] exp_v;
      @(posedge clk); #1;
      exp_v = 4'b0000;
      if (i % 3 == 0) exp_v = ((i / 3) % 2 == 0) ? 4'b1000 : 4'b0100;
      if (i % 3 == 1) exp_v = ((i / 3) % 2 == 0) ? 4'b0010 : 4'b0001;
      chk("rr_gnt_done", {a_gnt, b_gnt, a_done, b_done}, exp_v);
      if (i == 9) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end

    // Reset in the middle of a write's ACCESS cycle.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h0077);
    @(posedge clk); #1;
    chk("rst_access", {a_gnt, mem_write}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("rst_outs", {a_gnt, b_gnt, a_done, b_done, busy, mem_read, mem_write, mem_addr},
        23'h0);
    a_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mem_4_kept", mem[4], 8'h5E);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_done", {a_done, b_done, busy}, 3'b000);
    end
    push_exp(1'b0, 1'b0, 1'b0, 16'h0004);
    push_exp(1'b1, 1'b0, 1'b1, 16'h0004);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000);
    @(posedge clk); #1;
    chk("post_rst_gnt_a", {a_gnt, b_gnt}, 2'b10);
    a_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_gnt_b", {a_gnt, b_gnt}, 2'b01);
    b_req = 1'b0;
    @(posedge clk); #1;
    chk("b_rdata_345e", b_rdata, 16'h345E);
    @(posedge clk); #1;

    // B arrives while A is in ACCESS; A has dropped its request.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
    push_exp(1'b0, 1'b0, 1'b1, 16'h0010);
    @(posedge clk); #1;
    chk("late_a_gnt", {a_gnt, b_gnt}, 2'b10);
    a_req = 1'b0;
    push_exp(1'b1, 1'b0, 1'b0, 16'h0005);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000);
    @(posedge clk); #1;
    chk("late_resp", {a_done, a_gnt, b_gnt}, 3'b100);
    @(posedge clk); #1;
    chk("late_idle", {a_gnt, b_gnt, busy}, 3'b000);
    @(posedge clk); #1;
    chk("late_b_gnt", {a_gnt, b_gnt}, 2'b01);
    b_req = 1'b0;
    @(posedge clk); #1;
    chk("late_b_done", {b_done, b_rdata}, {1'b1, 16'h0034});
    chk("late_a_held", a_rdata, 16'hBEEF);
    @(posedge clk); #1;

    chk("sb_a_empty", exp_a.size(), 0);
    chk("sb_b_empty", exp_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
